// File: rtl/m_tlb_sa_if.sv
// Lookup, fill and flush bus of the set-associative TLB.
// The MMU side drives it through the master modport and the TLB answers on the slave modport.
interface m_tlb_sa_if #(
    parameter int VPN_W  = 20,
    parameter int PPN_W  = 22,
    parameter int ASID_W = 9
);
    logic [VPN_W-1:0]  w_raddr;
    logic [ASID_W-1:0] w_rasid;
    logic              w_oe;
    logic [PPN_W-1:0]  w_odata;
    logic [7:0]        w_operm;
    logic              w_omega;
    logic              w_we;
    logic [VPN_W-1:0]  w_waddr;
    logic [ASID_W-1:0] w_wasid;
    logic [PPN_W-1:0]  w_wdata;
    logic [7:0]        w_wperm;
    logic              w_wmega;
    logic              w_flush;
    logic [1:0]        w_flush_mode;
    logic [VPN_W-1:0]  w_flush_vpn;
    logic [ASID_W-1:0] w_flush_asid;
    logic              w_busy;

    modport master (
        output w_raddr, w_rasid, w_we, w_waddr, w_wasid, w_wdata, w_wperm, w_wmega,
               w_flush, w_flush_mode, w_flush_vpn, w_flush_asid,
        input  w_oe, w_odata, w_operm, w_omega, w_busy
    );

    modport slave (
        input  w_raddr, w_rasid, w_we, w_waddr, w_wasid, w_wdata, w_wperm, w_wmega,
               w_flush, w_flush_mode, w_flush_vpn, w_flush_asid,
        output w_oe, w_odata, w_operm, w_omega, w_busy
    );
endinterface

// File: rtl/m_tlb_sa.sv
// Set-associative 4 KiB TLB with a small fully-associative megapage array.
// Entries are ASID-tagged; selective flushes walk one set per cycle.
module m_tlb_sa #(
    parameter int VPN_W      = 20,
    parameter int PPN_W      = 22,
    parameter int ASID_W     = 9,
    parameter int SETS       = 8,
    parameter int WAYS       = 2,
    parameter int MEGA       = 4,
    parameter int MEGA_SHIFT = 10
) (
    input logic        CLK,
    input logic        RST,
    m_tlb_sa_if.slave  bus
);
    localparam int SET_W  = $clog2(SETS);
    localparam int TAG_W  = VPN_W - SET_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int MEGA_W = (MEGA > 1) ? $clog2(MEGA) : 1;
    localparam int MTAG_W = VPN_W - MEGA_SHIFT;
    localparam int MPPN_W = PPN_W - MEGA_SHIFT;

    typedef enum logic [0:0] {IDLE, SWEEP} stateT;

    stateT             stateQ, stateD;
    logic [SET_W-1:0]  sweepIdxQ, sweepIdxD;
    logic [1:0]        flushModeQ, flushModeD;
    logic [VPN_W-1:0]  flushVpnQ, flushVpnD;
    logic [ASID_W-1:0] flushAsidQ, flushAsidD;

    logic              validQ [SETS][WAYS];
    logic              validD [SETS][WAYS];
    logic [TAG_W-1:0]  tagQ   [SETS][WAYS];
    logic [TAG_W-1:0]  tagD   [SETS][WAYS];
    logic [ASID_W-1:0] asidQ  [SETS][WAYS];
    logic [ASID_W-1:0] asidD  [SETS][WAYS];
    logic [PPN_W-1:0]  ppnQ   [SETS][WAYS];
    logic [PPN_W-1:0]  ppnD   [SETS][WAYS];
    logic [7:0]        permQ  [SETS][WAYS];
    logic [7:0]        permD  [SETS][WAYS];
    logic [WAY_W-1:0]  rrQ    [SETS];
    logic [WAY_W-1:0]  rrD    [SETS];

    logic              megaValidQ [MEGA];
    logic              megaValidD [MEGA];
    logic [MTAG_W-1:0] megaTagQ   [MEGA];
    logic [MTAG_W-1:0] megaTagD   [MEGA];
    logic [ASID_W-1:0] megaAsidQ  [MEGA];
    logic [ASID_W-1:0] megaAsidD  [MEGA];
    logic [MPPN_W-1:0] megaPpnQ   [MEGA];
    logic [MPPN_W-1:0] megaPpnD   [MEGA];
    logic [7:0]        megaPermQ  [MEGA];
    logic [7:0]        megaPermD  [MEGA];
    logic [MEGA_W-1:0] megaRrQ, megaRrD;

    logic [SET_W-1:0]  rSet, wSet;
    logic [TAG_W-1:0]  rTag, wTag;
    logic              hit4, hitM;
    logic [WAY_W-1:0]  hitWay;
    logic [MEGA_W-1:0] hitIdx;
    logic              wMatch, wInv, mMatch, mInv;
    logic [WAY_W-1:0]  wMatchWay, wInvWay, fillWay;
    logic [MEGA_W-1:0] mMatchIdx, mInvIdx, fillIdx;
    logic              asidOk, vpnOk;
    logic              fillEn;

    assign rSet   = bus.w_raddr[SET_W-1:0];
    assign rTag   = bus.w_raddr[VPN_W-1:SET_W];
    assign wSet   = bus.w_waddr[SET_W-1:0];
    assign wTag   = bus.w_waddr[VPN_W-1:SET_W];
    assign fillEn = bus.w_we && (stateQ == IDLE);

    // Lookup: descending scans so the lowest matching index is the one left selected.
    always_comb begin
        hit4   = 1'b0;
        hitWay = '0;
        hitM   = 1'b0;
        hitIdx = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (validQ[rSet][w] && tagQ[rSet][w] == rTag &&
                (permQ[rSet][w][5] || asidQ[rSet][w] == bus.w_rasid)) begin
                hit4   = 1'b1;
                hitWay = WAY_W'(w);
            end
        end
        for (int m = MEGA - 1; m >= 0; m--) begin
            if (megaValidQ[m] && megaTagQ[m] == bus.w_raddr[VPN_W-1:MEGA_SHIFT] &&
                (megaPermQ[m][5] || megaAsidQ[m] == bus.w_rasid)) begin
                hitM   = 1'b1;
                hitIdx = MEGA_W'(m);
            end
        end
    end

    // Output mux: a 4 KiB hit takes priority and the sweep hides every hit.
    always_comb begin
        bus.w_busy  = (stateQ == SWEEP);
        bus.w_oe    = (stateQ == IDLE) && (hit4 || hitM);
        bus.w_omega = (stateQ == IDLE) && !hit4 && hitM;
        if (hit4) begin
            bus.w_odata = ppnQ[rSet][hitWay];
            bus.w_operm = permQ[rSet][hitWay];
        end else begin
            bus.w_odata = {megaPpnQ[hitIdx], bus.w_raddr[MEGA_SHIFT-1:0]};
            bus.w_operm = megaPermQ[hitIdx];
        end
    end

    // Fill victim choice: same-translation entry, else first free slot, else round-robin.
    always_comb begin
        wMatch    = 1'b0;
        wMatchWay = '0;
        wInv      = 1'b0;
        wInvWay   = '0;
        mMatch    = 1'b0;
        mMatchIdx = '0;
        mInv      = 1'b0;
        mInvIdx   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (validQ[wSet][w] && tagQ[wSet][w] == wTag &&
                (permQ[wSet][w][5] || asidQ[wSet][w] == bus.w_wasid)) begin
                wMatch    = 1'b1;
                wMatchWay = WAY_W'(w);
            end
            if (!validQ[wSet][w]) begin
                wInv    = 1'b1;
                wInvWay = WAY_W'(w);
            end
        end
        for (int m = MEGA - 1; m >= 0; m--) begin
            if (megaValidQ[m] && megaTagQ[m] == bus.w_waddr[VPN_W-1:MEGA_SHIFT] &&
                (megaPermQ[m][5] || megaAsidQ[m] == bus.w_wasid)) begin
                mMatch    = 1'b1;
                mMatchIdx = MEGA_W'(m);
            end
            if (!megaValidQ[m]) begin
                mInv    = 1'b1;
                mInvIdx = MEGA_W'(m);
            end
        end
        fillWay = wMatch ? wMatchWay : (wInv ? wInvWay : rrQ[wSet]);
        fillIdx = mMatch ? mMatchIdx : (mInv ? mInvIdx : megaRrQ);
    end

    // Flush/sweep controller: latches the flush request and steps one set per cycle.
    always_comb begin
        stateD     = stateQ;
        sweepIdxD  = sweepIdxQ;
        flushModeD = flushModeQ;
        flushVpnD  = flushVpnQ;
        flushAsidD = flushAsidQ;
        case (stateQ)
            IDLE: begin
                if (bus.w_flush && bus.w_flush_mode != 2'd0) begin
                    stateD     = SWEEP;
                    sweepIdxD  = '0;
                    flushModeD = bus.w_flush_mode;
                    flushVpnD  = bus.w_flush_vpn;
                    flushAsidD = bus.w_flush_asid;
                end
            end
            SWEEP: begin
                if (sweepIdxQ == SET_W'(SETS - 1)) begin
                    stateD = IDLE;
                end else begin
                    sweepIdxD = sweepIdxQ + 1'b1;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // Array next state: sweep invalidation, then flush-all, then the fill so a same-cycle fill survives.
    always_comb begin
        validD     = validQ;
        tagD       = tagQ;
        asidD      = asidQ;
        ppnD       = ppnQ;
        permD      = permQ;
        rrD        = rrQ;
        megaValidD = megaValidQ;
        megaTagD   = megaTagQ;
        megaAsidD  = megaAsidQ;
        megaPpnD   = megaPpnQ;
        megaPermD  = megaPermQ;
        megaRrD    = megaRrQ;
        asidOk     = 1'b0;
        vpnOk      = 1'b0;
        if (stateQ == SWEEP) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    asidOk = !flushModeQ[0] || (asidQ[s][w] == flushAsidQ && !permQ[s][w][5]);
                    vpnOk  = !flushModeQ[1] || ({tagQ[s][w], SET_W'(s)} == flushVpnQ);
                    if (SET_W'(s) == sweepIdxQ && asidOk && vpnOk) begin
                        validD[s][w] = 1'b0;
                    end
                end
            end
            for (int m = 0; m < MEGA; m++) begin
                asidOk = !flushModeQ[0] || (megaAsidQ[m] == flushAsidQ && !megaPermQ[m][5]);
                vpnOk  = !flushModeQ[1] || (megaTagQ[m] == flushVpnQ[VPN_W-1:MEGA_SHIFT]);
                if (sweepIdxQ == '0 && asidOk && vpnOk) begin
                    megaValidD[m] = 1'b0;
                end
            end
        end
        if (stateQ == IDLE && bus.w_flush && bus.w_flush_mode == 2'd0) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    validD[s][w] = 1'b0;
                end
            end
            for (int m = 0; m < MEGA; m++) begin
                megaValidD[m] = 1'b0;
            end
        end
        if (fillEn && bus.w_wmega) begin
            megaValidD[fillIdx] = 1'b1;
            megaTagD[fillIdx]   = bus.w_waddr[VPN_W-1:MEGA_SHIFT];
            megaAsidD[fillIdx]  = bus.w_wasid;
            megaPpnD[fillIdx]   = bus.w_wdata[PPN_W-1:MEGA_SHIFT];
            megaPermD[fillIdx]  = bus.w_wperm;
            if (!mMatch && !mInv) begin
                megaRrD = (megaRrQ == MEGA_W'(MEGA - 1)) ? '0 : megaRrQ + 1'b1;
            end
        end else if (fillEn) begin
            validD[wSet][fillWay] = 1'b1;
            tagD[wSet][fillWay]   = wTag;
            asidD[wSet][fillWay]  = bus.w_wasid;
            ppnD[wSet][fillWay]   = bus.w_wdata;
            permD[wSet][fillWay]  = bus.w_wperm;
            if (!wMatch && !wInv) begin
                rrD[wSet] = (rrQ[wSet] == WAY_W'(WAYS - 1)) ? '0 : rrQ[wSet] + 1'b1;
            end
        end
    end

    // State and array registers; reset drops every valid bit, every pointer and any sweep.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stateQ    <= IDLE;
            sweepIdxQ <= '0;
            megaRrQ   <= '0;
            for (int s = 0; s < SETS; s++) begin
                rrQ[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    validQ[s][w] <= 1'b0;
                end
            end
            for (int m = 0; m < MEGA; m++) begin
                megaValidQ[m] <= 1'b0;
            end
        end else begin
            stateQ     <= stateD;
            sweepIdxQ  <= sweepIdxD;
            megaRrQ    <= megaRrD;
            rrQ        <= rrD;
            validQ     <= validD;
            megaValidQ <= megaValidD;
        end
        flushModeQ <= flushModeD;
        flushVpnQ  <= flushVpnD;
        flushAsidQ <= flushAsidD;
        tagQ       <= tagD;
        asidQ      <= asidD;
        ppnQ       <= ppnD;
        permQ      <= permD;
        megaTagQ   <= megaTagD;
        megaAsidQ  <= megaAsidD;
        megaPpnQ   <= megaPpnD;
        megaPermQ  <= megaPermD;
    end
endmodule

// File: tb/tb_m_tlb_sa.sv
// Directed bench for m_tlb_sa: lookups, fills, eviction, flush sweeps and reset.
module tb_m_tlb_sa;
    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;

    m_tlb_sa_if #(.VPN_W(20), .PPN_W(22), .ASID_W(9)) bus ();

    m_tlb_sa #(
        .VPN_W(20), .PPN_W(22), .ASID_W(9), .SETS(8), .WAYS(2), .MEGA(4), .MEGA_SHIFT(10)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    // 100 MHz free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison goes through here
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One fill; returns one cycle later at edge+1
    task automatic applyFill(input logic [19:0] vpn, input logic [8:0] asid, input logic [21:0] ppn,
                             input logic [7:0] perm, input logic mega);
        bus.w_we    = 1'b1;
        bus.w_waddr = vpn;
        bus.w_wasid = asid;
        bus.w_wdata = ppn;
        bus.w_wperm = perm;
        bus.w_wmega = mega;
        @(posedge clk);
        #1;
        bus.w_we    = 1'b0;
    endtask

    // One flush pulse; returns at edge+1
    task automatic applyFlush(input logic [1:0] mode, input logic [19:0] vpn, input logic [8:0] asid);
        bus.w_flush      = 1'b1;
        bus.w_flush_mode = mode;
        bus.w_flush_vpn  = vpn;
        bus.w_flush_asid = asid;
        @(posedge clk);
        #1;
        bus.w_flush      = 1'b0;
    endtask

    // Lookup sampled at the falling edge, returns at the next edge+1
    task automatic applyStimulus(input logic [19:0] vpn, input logic [8:0] asid,
                                 output logic oe, output logic [21:0] data,
                                 output logic [7:0] perm, output logic mega);
        bus.w_raddr = vpn;
        bus.w_rasid = asid;
        @(negedge clk);
        oe   = bus.w_oe;
        data = bus.w_odata;
        perm = bus.w_operm;
        mega = bus.w_omega;
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the sweep to finish
    task automatic waitIdle();
        int n;
        n = 0;
        while (bus.w_busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("sweepTimeout", 32'(bus.w_busy), 32'd0);
    endtask

    logic        oe;
    logic [21:0] data;
    logic [7:0]  perm;
    logic        mega;
    int          busyCycles;
    logic        oeDuringSweep;

    // Directed scenario sequence
    initial begin
        checkCount = 0;
        errorCount = 0;
        rst = 1'b1;
        bus.w_raddr = '0; bus.w_rasid = '0; bus.w_we = 1'b0; bus.w_waddr = '0;
        bus.w_wasid = '0; bus.w_wdata = '0; bus.w_wperm = '0; bus.w_wmega = 1'b0;
        bus.w_flush = 1'b0; bus.w_flush_mode = '0; bus.w_flush_vpn = '0; bus.w_flush_asid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and first translation
        checkOutput("resetBusy", 32'(bus.w_busy), 32'd0);
        applyStimulus(20'h00123, 9'd1, oe, data, perm, mega);
        checkOutput("resetMiss", 32'(oe), 32'd0);
        checkOutput("resetMega", 32'(mega), 32'd0);
        applyFill(20'h00123, 9'd1, 22'h0ABCD, 8'hCF, 1'b0);
        applyStimulus(20'h00123, 9'd1, oe, data, perm, mega);
        checkOutput("fillHit", 32'(oe), 32'd1);
        checkOutput("fillData", 32'(data), 32'h0ABCD);
        checkOutput("fillPerm", 32'(perm), 32'hCF);
        checkOutput("fillNotMega", 32'(mega), 32'd0);
        applyStimulus(20'h00123, 9'd2, oe, data, perm, mega);
        checkOutput("otherAsidMiss", 32'(oe), 32'd0);

        // Megapage translation keeps the low VPN bits
        applyFill(20'h40000, 9'd3, 22'h100000, 8'h0F, 1'b1);
        applyStimulus(20'h40155, 9'd3, oe, data, perm, mega);
        checkOutput("megaHit", 32'(oe), 32'd1);
        checkOutput("megaData", 32'(data), 32'h100155);
        checkOutput("megaFlag", 32'(mega), 32'd1);

        // Round-robin eviction and in-place refill in set 0
        applyFill(20'h00008, 9'd0, 22'h81, 8'h0F, 1'b0);
        applyFill(20'h00010, 9'd0, 22'h82, 8'h0F, 1'b0);
        applyFill(20'h00018, 9'd0, 22'h83, 8'h0F, 1'b0);
        applyStimulus(20'h00008, 9'd0, oe, data, perm, mega);
        checkOutput("evictedMiss", 32'(oe), 32'd0);
        applyStimulus(20'h00010, 9'd0, oe, data, perm, mega);
        checkOutput("keep10Data", 32'(data), 32'h82);
        applyStimulus(20'h00018, 9'd0, oe, data, perm, mega);
        checkOutput("keep18Hit", 32'(oe), 32'd1);
        checkOutput("keep18Data", 32'(data), 32'h83);
        applyFill(20'h00010, 9'd0, 22'h55, 8'h0F, 1'b0);
        applyStimulus(20'h00010, 9'd0, oe, data, perm, mega);
        checkOutput("refillData", 32'(data), 32'h55);
        applyStimulus(20'h00018, 9'd0, oe, data, perm, mega);
        checkOutput("refill18Hit", 32'(oe), 32'd1);
        checkOutput("refill18Data", 32'(data), 32'h83);

        // Flush by ASID spares global entries and lasts exactly 8 cycles
        applyFill(20'h00205, 9'd5, 22'h205, 8'h0F, 1'b0);
        applyFill(20'h00206, 9'd5, 22'h206, 8'h2F, 1'b0);
        applyFlush(2'd1, 20'h0, 9'd5);
        checkOutput("sweepBusy", 32'(bus.w_busy), 32'd1);
        bus.w_raddr = 20'h00206;
        bus.w_rasid = 9'd5;
        busyCycles = 0;
        oeDuringSweep = 1'b0;
        while (bus.w_busy && busyCycles < 40) begin
            @(negedge clk);
            if (bus.w_busy) begin
                busyCycles++;
                oeDuringSweep = oeDuringSweep | bus.w_oe;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("sweepLength", 32'(busyCycles), 32'd8);
        checkOutput("sweepHidesHit", 32'(oeDuringSweep), 32'd0);
        applyStimulus(20'h00205, 9'd5, oe, data, perm, mega);
        checkOutput("asidFlushedA", 32'(oe), 32'd0);
        applyStimulus(20'h00206, 9'd5, oe, data, perm, mega);
        checkOutput("globalKeptB", 32'(oe), 32'd1);
        checkOutput("globalKeptData", 32'(data), 32'h206);

        // Flush by VPN: megapage covering 0x40123 goes, 4 KiB neighbour stays
        applyFill(20'h40124, 9'd3, 22'h777, 8'h0F, 1'b0);
        applyStimulus(20'h40124, 9'd3, oe, data, perm, mega);
        checkOutput("prio4kData", 32'(data), 32'h777);
        checkOutput("prio4kMega", 32'(mega), 32'd0);
        applyFlush(2'd2, 20'h40123, 9'd0);
        waitIdle();
        applyStimulus(20'h40155, 9'd3, oe, data, perm, mega);
        checkOutput("vpnFlushMega", 32'(oe), 32'd0);
        applyStimulus(20'h40124, 9'd3, oe, data, perm, mega);
        checkOutput("vpnKeep4k", 32'(oe), 32'd1);
        checkOutput("vpnKeep4kData", 32'(data), 32'h777);

        // Reset during sweep cycle 3 aborts the sweep and empties the TLB
        applyFlush(2'd1, 20'h0, 9'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("resetAbortBusy", 32'(bus.w_busy), 32'd0);
        applyStimulus(20'h00206, 9'd5, oe, data, perm, mega);
        checkOutput("resetClearGlobal", 32'(oe), 32'd0);
        applyStimulus(20'h40124, 9'd3, oe, data, perm, mega);
        checkOutput("resetClear4k", 32'(oe), 32'd0);

        // Flush-all with a simultaneous fill keeps only the new entry
        applyFill(20'h00123, 9'd1, 22'h0ABCD, 8'h0F, 1'b0);
        bus.w_we    = 1'b1;
        bus.w_waddr = 20'h00402;
        bus.w_wasid = 9'd2;
        bus.w_wdata = 22'h42;
        bus.w_wperm = 8'h0F;
        bus.w_wmega = 1'b0;
        applyFlush(2'd0, 20'h0, 9'd0);
        bus.w_we = 1'b0;
        checkOutput("flushAllNoBusy", 32'(bus.w_busy), 32'd0);
        applyStimulus(20'h00123, 9'd1, oe, data, perm, mega);
        checkOutput("flushAllOld", 32'(oe), 32'd0);
        applyStimulus(20'h00402, 9'd2, oe, data, perm, mega);
        checkOutput("flushAllNewHit", 32'(oe), 32'd1);
        checkOutput("flushAllNewData", 32'(data), 32'h42);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
        $finish;
    end
endmodule
